// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encodings and default sizing.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_HOLD_MAX = 8;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// last_owner+1, wrapping modulo NUM_REQ.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   next_idx,
  output logic               found
);

  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // cand[gi] is the requester gi+1 steps after last_owner; one conditional
  // subtract suffices because the sum never reaches 2*NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SUM_W-1:0] sum;
      assign sum       = {1'b0, last_owner} + SUM_W'(gi + 1);
      assign cand[gi]  = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                  : sum[IDX_W-1:0];
      assign hit[gi]   = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    found    = |hit;
    next_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) next_idx = cand[i];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin tri-state bus arbiter with per-grant hold limit.
// Define BUS_ARBITER_TURNAROUND_EN to insert a one-cycle bus float between owners.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] buf_en,
  output logic [IDX_W-1:0]   owner,
  output logic               busy
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   last_owner_reg, last_owner_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] buf_en_reg;
  logic               busy_reg;

  logic [IDX_W-1:0]   pick_base;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               owner_req;
  logic               others_waiting;

  // While granting, the search starts after the current owner so a direct
  // handoff never re-picks it ahead of waiting requesters.
  assign pick_base = (state_reg == ST_GRANT) ? owner_reg : last_owner_reg;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req       (req),
    .last_owner(pick_base),
    .next_idx  (pick_idx),
    .found     (pick_found)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end
  endgenerate

  assign owner_req      = |(req & gnt_reg);
  assign others_waiting = |(req & ~gnt_reg);

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    gnt_next        = gnt_reg;
    case (state_reg)
      ST_GRANT: begin
        if (owner_req && (hold_cnt_reg != HOLD_LAST || !others_waiting)) begin
          if (hold_cnt_reg != HOLD_LAST) hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end else begin
          last_owner_next = owner_reg;
          hold_cnt_next   = '0;
          gnt_next        = '0;
`ifdef BUS_ARBITER_TURNAROUND_EN
          state_next      = ST_TURN;
`else
          if (pick_found) begin
            state_next = ST_GRANT;
            owner_next = pick_idx;
            gnt_next   = pick_onehot;
          end else begin
            state_next = ST_IDLE;
          end
`endif
        end
      end
      default: begin
        hold_cnt_next = '0;
        if (pick_found) begin
          state_next = ST_GRANT;
          owner_next = pick_idx;
          gnt_next   = pick_onehot;
        end else begin
          state_next = ST_IDLE;
          gnt_next   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      hold_cnt_reg   <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDX_W'(NUM_REQ - 1);
      gnt_reg        <= '0;
      buf_en_reg     <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      gnt_reg        <= gnt_next;
      buf_en_reg     <= gnt_next;
      busy_reg       <= |gnt_next;
    end
  end

  assign gnt    = gnt_reg;
  assign buf_en = buf_en_reg;
  assign owner  = owner_reg;
  assign busy   = busy_reg;

endmodule
